// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache fills and dcache reads/writes onto one RAM port.
// Dcache has priority; a starve counter forces an icache grant. ARB_ERRCNT_EN adds err_count.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [ADDR_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic              dwait,
    output logic [ADDR_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic [15:0]       err_count
);
    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;
    state_t state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic d_act, d_done, i_done;
    assign d_act  = dREN | dWEN;
    // A withdrawn requester never completes, even if the RAM reports ACCESS.
    assign d_done = (state_q == DGRANT) && d_act && (ramstate == ACCESS);
    assign i_done = (state_q == IGRANT) && iREN && (ramstate == ACCESS);
    assign iload  = ramload;
    assign dload  = ramload;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = !i_done;
        dwait    = !d_done;
        case (state_q)
            IDLE: state_d = (iREN && starve_q == LIMIT) ? IGRANT :
                            d_act ? DGRANT : iREN ? IGRANT : IDLE;
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!d_act || d_done)
                    state_d = IDLE;
                if (d_done)
                    starve_d = !iREN ? '0 : (starve_q == LIMIT) ? starve_q : starve_q + 1'b1;
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN || i_done)
                    state_d = IDLE;
                if (i_done)
                    starve_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
`ifdef ARB_ERRCNT_EN
    logic [15:0] err_q, err_d;
    always_comb
        err_d = (state_q != IDLE && ramstate == ERROR && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            err_q <= '0;
        else
            err_q <= err_d;
    end
    assign err_count = err_q;
`else
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus checked against a cycle-level
// ownership model of the arbiter.
module tb_mem_arbiter;
    localparam int LIM = 4;
    logic CLK = 0, nRST = 0;
    logic iREN = 0, dREN = 0, dWEN = 0;
    logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
    logic [1:0] ramstate = 0;
    logic iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [15:0] err_count;
    int n_chk = 0, n_fail = 0;
    int own = 0, starve = 0;
    logic [15:0] err_m = 0;
    string log_s = "";

    mem_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err_count(err_count));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_err", err_count, 0);
    endtask

    // own: 0 nobody holds the RAM, 1 dcache holds it, 2 icache holds it
    task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] ds,
                        input logic [1:0] rs, input logic [31:0] rl);
        logic d_act, acc, e_ren, e_wen, d_fin, i_fin;
        logic [31:0] e_addr, e_store;
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
        ramstate = rs; ramload = rl;
        #1;
        d_act = dr | dw;
        acc = (rs == 2'd2);
        d_fin = (own == 1) && d_act && acc;
        i_fin = (own == 2) && ir && acc;
        e_ren = (own == 1) ? (dr & ~dw) : (own == 2) ? ir : 1'b0;
        e_wen = (own == 1) ? dw : 1'b0;
        e_addr = (own == 1) ? da : (own == 2) ? ia : 32'd0;
        e_store = (own == 1) ? ds : 32'd0;
        chk("ramREN", ramREN, e_ren);
        chk("ramWEN", ramWEN, e_wen);
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
        chk("dwait", dwait, !d_fin);
        chk("iwait", iwait, !i_fin);
        chk("iload", iload, rl);
        chk("dload", dload, rl);
        chk("err_count", err_count, err_m);
        if (!dwait) log_s = {log_s, "D"};
        if (!iwait) log_s = {log_s, "I"};
`ifdef ARB_ERRCNT_EN
        if (own != 0 && rs == 2'd3 && err_m != 16'hFFFF) err_m = err_m + 1;
`endif
        if (own == 0) begin
            if (ir && starve == LIM) own = 2;
            else if (d_act) own = 1;
            else if (ir) own = 2;
        end else if (own == 1) begin
            if (d_fin) starve = ir ? ((starve < LIM) ? starve + 1 : LIM) : 0;
            if (!d_act || d_fin) own = 0;
        end else begin
            if (i_fin) starve = 0;
            if (!ir || i_fin) own = 0;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1;
        chk_reset_vals();
        @(posedge CLK);
        #1;
        nRST = 1;
        // icache single read with two BUSY cycles
        log_s = "";
        step(1, 32'h40, 0, 0, 0, 0, 2'd0, 0);
        step(1, 32'h40, 0, 0, 0, 0, 2'd1, 0);
        step(1, 32'h40, 0, 0, 0, 0, 2'd1, 0);
        step(1, 32'h40, 0, 0, 0, 0, 2'd2, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 2'd0, 0);
        chk("ifill_once", 32'(log_s == "I"), 1);
        // dcache write, immediate ACCESS
        log_s = "";
        step(0, 0, 0, 1, 32'h100, 32'h12345678, 2'd0, 0);
        step(0, 0, 0, 1, 32'h100, 32'h12345678, 2'd2, 0);
        step(0, 0, 0, 0, 0, 0, 2'd0, 0);
        chk("dwrite_once", 32'(log_s == "D"), 1);
        // simultaneous requests: dcache first, then icache
        log_s = "";
        step(1, 32'h80, 1, 0, 32'h200, 0, 2'd0, 0);
        step(1, 32'h80, 1, 0, 32'h200, 0, 2'd2, 32'h11);
        step(1, 32'h80, 0, 0, 0, 0, 2'd0, 0);
        step(1, 32'h80, 0, 0, 0, 0, 2'd2, 32'h22);
        step(0, 0, 0, 0, 0, 0, 2'd0, 0);
        chk("simul_order", 32'(log_s == "DI"), 1);
        // starvation: four dcache completions then a forced icache grant
        log_s = "";
        for (int k = 0; k < 20; k++)
            step(1, 32'h90, 1, 0, 32'h300 + 32'(k), 0, 2'd2, 32'(k));
        chk("starve_order", 32'(log_s == "DDDDIDDDDI"), 1);
        step(0, 0, 0, 0, 0, 0, 2'd0, 0);
        // withdrawal during BUSY
        log_s = "";
        step(0, 0, 1, 0, 32'h400, 0, 2'd0, 0);
        step(0, 0, 1, 0, 32'h400, 0, 2'd1, 0);
        step(0, 0, 0, 0, 32'h400, 0, 2'd1, 0);
        step(0, 0, 0, 0, 0, 0, 2'd0, 0);
        chk("withdraw_nopulse", 32'(log_s == ""), 1);
        // asynchronous reset during IGRANT
        step(1, 32'h44, 0, 0, 0, 0, 2'd0, 0);
        ramstate = 2'd1;
        #1;
        chk("igrant_ren", ramREN, 1);
        chk("igrant_addr", ramaddr, 32'h44);
        nRST = 0;
        #1;
        chk_reset_vals();
        own = 0; starve = 0; err_m = 0;
        @(posedge CLK);
        #1;
        nRST = 1;
        // three ERROR cycles, then ACCESS, during IGRANT
        log_s = "";
        step(1, 32'h50, 0, 0, 0, 0, 2'd0, 0);
        for (int k = 0; k < 3; k++) step(1, 32'h50, 0, 0, 0, 0, 2'd3, 0);
        step(1, 32'h50, 0, 0, 0, 0, 2'd2, 32'hCAFE);
        step(0, 0, 0, 0, 0, 0, 2'd0, 0);
        chk("err_ifill_once", 32'(log_s == "I"), 1);
`ifdef ARB_ERRCNT_EN
        chk("err_three", err_count, 3);
`else
        chk("err_zero", err_count, 0);
`endif
        // random traffic
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 5,
                 $urandom_range(0, 9) < 3, $urandom, $urandom,
                 2'($urandom_range(0, 3)), $urandom);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter between the instruction cache and data cache miss paths and the shared RAM port.
- Serialises icache fills and dcache reads/writes onto one RAM interface.
- Returns per-requester wait/load signals.
- Dcache has priority; a bounded starvation counter guarantees icache progress.

Parameters:
- STARVE_LIMIT, 4: consecutive dcache grants allowed while an icache request is pending before one icache grant is forced.
- ADDR_W, 32: address and data width (word_t).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache fill request
- iaddr  in  ADDR_W  icache word address
- iwait  out  1  icache wait; low for exactly the completing cycle
- iload  out  ADDR_W  icache fill data
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache address
- dstore  in  ADDR_W  dcache write data
- dwait  out  1  dcache wait; low for exactly the completing cycle
- dload  out  ADDR_W  dcache read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  ADDR_W  RAM write data
- ramload  in  ADDR_W  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- err_count  out  16  RAM error-cycle count (optional feature)

Behaviour:
- Reset values:
  - state IDLE, starve counter 0
  - iwait=1, dwait=1
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0
  - err_count=0
- iload and dload are combinational pass-throughs of ramload at all times. They are valid only when the matching wait is low.
- States: IDLE, DGRANT, IGRANT. The state is registered; RAM drive and wait outputs decode combinationally from the state and ramstate.
- IDLE transitions:
  - No RAM drive; both waits high.
  - If iREN and starve==STARVE_LIMIT -> IGRANT.
  - Else if dREN|dWEN -> DGRANT.
  - Else if iREN -> IGRANT.
  - Else stay in IDLE.
- DGRANT:
  - Drive ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&!dWEN. dWEN wins if both are high.
  - On ramstate==ACCESS: dwait=0 for that cycle, then go to IDLE.
  - On completion, if iREN is high, starve increments (saturating at STARVE_LIMIT). If iREN is low, starve clears.
- IGRANT:
  - Drive ramaddr=iaddr, ramREN=1, ramWEN=0.
  - On ramstate==ACCESS: iwait=0 for that cycle, then go to IDLE, and starve clears.
- Minimum latency: request seen in IDLE at cycle 0, grant state at cycle 1, earliest completion at cycle 1 if the RAM returns ACCESS immediately. There is always at least one IDLE cycle between transactions.
- FREE, BUSY or ERROR in a grant state: hold the state and the drive, keep the wait high. ERROR is retried indefinitely.
- Requester withdrawal: if the granted requester's enables drop before ACCESS, return to IDLE next cycle. Deassert ram enables combinationally in that cycle; no wait pulse is produced.
- Simultaneous requests in IDLE: dcache wins unless starve==STARVE_LIMIT.
- Requests arriving during another grant are held off by wait=1 until they are served.
- Reset asserted mid-transaction: immediate return to reset values. The RAM request drops asynchronously.

Optional Feature:
- Macro ARB_ERRCNT_EN.
- Defined: err_count increments each cycle a grant state sees ramstate==ERROR, saturating at 16'hFFFF, cleared only by reset.
- Undefined: err_count is tied to 0 and no counter flops exist.

Test Plan:
- Icache only, single read: iREN=1, iaddr=0x40, RAM gives ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF. Required: ramREN=1 with ramaddr=0x40; iwait low for exactly 1 cycle with iload=0xDEADBEEF; then IDLE.
- Dcache write: dWEN=1, daddr=0x100, dstore=0x12345678, immediate ACCESS. Required: ramWEN=1, ramREN=0, ramstore=0x12345678; dwait low for 1 cycle.
- Simultaneous iREN and dREN in IDLE. Required: dcache is served first; icache is served next after one IDLE cycle; iwait stays high throughout the dcache transaction.
- Starvation: iREN held high, dREN reasserted continuously, STARVE_LIMIT=4. Required: 4 dcache completions, then an icache grant, then dcache again.
- Withdrawal and reset: dREN dropped during BUSY. Required: ramREN=0 the same cycle and IDLE next cycle. nRST pulsed during IGRANT: all outputs immediately return to reset values.
- ARB_ERRCNT_EN defined: 3 ERROR cycles then ACCESS during IGRANT. Required: err_count=3 and iwait pulses once. Undefined: err_count stays 0.
